updown_counter_mod: RTL and testbench

Parametrised up/down counter, successor to the fixed 4-bit up/down counter.
- Adds modulus, wrap/saturate mode, synchronous load, synchronous clear, count enable, boundary flags, a terminal-count pulse and a sticky overflow.
- Used as a general event/position counter in datapath and control blocks. One instance counts one channel.

---
 rtl/counter_pkg.sv | 16 +
 rtl/counter_next_val.sv | 45 ++++
 rtl/updown_counter_mod.sv | 80 ++++++++
 tb/tb_updown_counter_mod.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and parameter-legality check for the up/down counter family.
package counter_pkg;

    localparam logic CNT_MODE_WRAP = 1'b0;
    localparam logic CNT_MODE_SAT  = 1'b1;

    // True when WIDTH is in 2..32 and MODULUS fits in 2..2**WIDTH.
    function automatic bit params_ok(input int width, input longint modulus);
        if (width < 2 || width > 32)
            return 1'b0;
        if (modulus < 2 || modulus > (longint'(1) << width))
            return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/counter_next_val.sv
// Combinational step for the counter: next value one step up or down within
// 0..MODULUS-1, plus a flag when the step lands on a range boundary.
module counter_next_val
    import counter_pkg::*;
#(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 16
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up_down,
    input  logic             sat,
    output logic [WIDTH-1:0] q_next,
    output logic             hit
);

    localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE  = (WIDTH+1)'(1);

    logic [WIDTH:0] qx;
    logic [WIDTH:0] nx;

    // One spare bit keeps q+1 at the top of a full-range counter exact.
    always_comb begin
        qx  = {1'b0, q};
        nx  = qx;
        hit = 1'b0;
        if (up_down) begin
            if (qx == MAXV) begin
                hit = 1'b1;
                nx  = (sat == CNT_MODE_SAT) ? qx : '0;
            end else begin
                nx  = qx + ONE;
            end
        end else begin
            if (qx == '0) begin
                hit = 1'b1;
                nx  = (sat == CNT_MODE_SAT) ? qx : MAXV;
            end else begin
                nx  = qx - ONE;
            end
        end
        q_next = WIDTH'(nx);
    end

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with modulus, wrap/saturate, load, clear,
// boundary decodes, terminal-count pulse and sticky overflow.
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sclr,
    input  logic             en,
    input  logic             up_down,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             at_max,
    output logic             at_zero,
    output logic             tc,
    output logic             ovf
);

    if (!params_ok(WIDTH, MODULUS)) begin : g_bad_params
        $error("updown_counter_mod: illegal WIDTH/MODULUS combination");
    end

    localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH-1:0] q_p0;
    logic             tc_p0;
    logic             ovf_p0;
    logic [WIDTH-1:0] step_q;
    logic             step_hit;
    logic [WIDTH-1:0] load_q;

    counter_next_val #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .q       (q_p0),
        .up_down (up_down),
        .sat     (sat),
        .q_next  (step_q),
        .hit     (step_hit)
    );

    // Out-of-range load values clamp to the top of the count range.
    assign load_q = ({1'b0, load_val} > MAXV) ? WIDTH'(MAXV) : load_val;

    // Stage p0: count register, terminal-count pulse, sticky overflow.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_p0   <= '0;
            tc_p0  <= 1'b0;
            ovf_p0 <= 1'b0;
        end else if (sclr) begin
            q_p0   <= '0;
            tc_p0  <= 1'b0;
            ovf_p0 <= 1'b0;
        end else if (load) begin
            q_p0   <= load_q;
            tc_p0  <= 1'b0;
        end else if (en) begin
            q_p0   <= step_q;
            tc_p0  <= step_hit;
            if (step_hit)
                ovf_p0 <= 1'b1;
        end else begin
            tc_p0  <= 1'b0;
        end
    end

    assign q       = q_p0;
    assign tc      = tc_p0;
    assign ovf     = ovf_p0;
    assign at_max  = ({1'b0, q_p0} == MAXV);
    assign at_zero = (q_p0 == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod: a MODULUS=10 instance plus a
// full-range MODULUS=16 instance driven from the same inputs.
module tb_updown_counter_mod;

    logic       clk = 1'b0;
    logic       clr, sclr, en, up_down, sat, load;
    logic [3:0] load_val;
    logic [3:0] q, q16;
    logic       at_max, at_zero, tc, ovf;
    logic       at_max16, at_zero16, tc16, ovf16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    updown_counter_mod #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .clr(clr), .sclr(sclr), .en(en), .up_down(up_down),
        .sat(sat), .load(load), .load_val(load_val), .q(q),
        .at_max(at_max), .at_zero(at_zero), .tc(tc), .ovf(ovf)
    );

    updown_counter_mod #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk(clk), .clr(clr), .sclr(sclr), .en(en), .up_down(up_down),
        .sat(sat), .load(load), .load_val(load_val), .q(q16),
        .at_max(at_max16), .at_zero(at_zero16), .tc(tc16), .ovf(ovf16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect10(input string tag, input int eq, input bit etc, input bit eovf);
        chk({tag, " q"}, q, eq);
        chk({tag, " tc"}, tc, etc);
        chk({tag, " ovf"}, ovf, eovf);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int  mq;
        bit  mt, mo;
        bit  e, u, s;

        clr = 1'b1; sclr = 1'b0; en = 1'b0; up_down = 1'b0; sat = 1'b0;
        load = 1'b0; load_val = 4'd0;
        #2;
        expect10("reset", 0, 1'b0, 1'b0);
        chk("reset at_zero", at_zero, 1'b1);
        chk("reset at_max", at_max, 1'b0);
        clr = 1'b0;

        // Build up ovf, then reach q=7 and reset asynchronously mid-cycle.
        load = 1'b1; load_val = 4'd9;
        step();
        chk("load9 q", q, 9);
        chk("load9 at_max", at_max, 1'b1);
        load = 1'b0; en = 1'b1; up_down = 1'b1; sat = 1'b0;
        step();
        expect10("pre wrap", 0, 1'b1, 1'b1);
        en = 1'b0; load = 1'b1; load_val = 4'd7;
        step();
        expect10("load7", 7, 1'b0, 1'b1);
        load = 1'b0;
        #3;
        clr = 1'b1;
        #1;
        expect10("async clr", 0, 1'b0, 1'b0);
        chk("async clr at_zero", at_zero, 1'b1);
        clr = 1'b0;

        // Wrap up from 8.
        load = 1'b1; load_val = 4'd8;
        step();
        expect10("load8", 8, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1; up_down = 1'b1; sat = 1'b0;
        step();
        expect10("up 9", 9, 1'b0, 1'b0);
        chk("up 9 at_max", at_max, 1'b1);
        step();
        expect10("up wrap 0", 0, 1'b1, 1'b1);
        chk("up wrap at_zero", at_zero, 1'b1);
        step();
        expect10("up 1", 1, 1'b0, 1'b1);
        chk("up 1 at_max", at_max, 1'b0);

        // Wrap down, then saturate at zero.
        en = 1'b0; load = 1'b1; load_val = 4'd0;
        step();
        expect10("load0", 0, 1'b0, 1'b1);
        load = 1'b0; en = 1'b1; up_down = 1'b0; sat = 1'b0;
        step();
        expect10("down wrap 9", 9, 1'b1, 1'b1);
        sat = 1'b1; load = 1'b1; load_val = 4'd0;
        step();
        expect10("load0 over en", 0, 1'b0, 1'b1);
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect10($sformatf("down sat %0d", i), 0, 1'b1, 1'b1);
        end

        // sclr beats load and en; then load beats en.
        sclr = 1'b1; load = 1'b1; load_val = 4'd5; en = 1'b1; up_down = 1'b1;
        step();
        expect10("sclr prio", 0, 1'b0, 1'b0);
        sclr = 1'b0;
        step();
        expect10("load prio", 5, 1'b0, 1'b0);

        // Clamp, then hold with direction toggling.
        load_val = 4'd13; en = 1'b0;
        step();
        expect10("clamp 13", 9, 1'b0, 1'b0);
        chk("clamp at_max", at_max, 1'b1);
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            up_down = ~up_down;
            step();
            expect10($sformatf("hold %0d", i), 9, 1'b0, 1'b0);
        end

        // Saturate at the top.
        en = 1'b1; up_down = 1'b1; sat = 1'b1;
        step();
        expect10("up sat 9", 9, 1'b1, 1'b1);
        en = 1'b0;
        step();
        expect10("tc drops", 9, 1'b0, 1'b1);

        // Full-range instance: 15 wraps to 0.
        sclr = 1'b1;
        step();
        chk("m16 sclr q", q16, 0);
        chk("m16 sclr ovf", ovf16, 1'b0);
        sclr = 1'b0; load = 1'b1; load_val = 4'd15;
        step();
        chk("m16 load15 q", q16, 15);
        chk("m16 at_max", at_max16, 1'b1);
        load = 1'b0; en = 1'b1; up_down = 1'b1; sat = 1'b0;
        step();
        chk("m16 wrap q", q16, 0);
        chk("m16 wrap tc", tc16, 1'b1);
        chk("m16 wrap at_zero", at_zero16, 1'b1);

        // Random en/up_down/sat against a modulo-16 reference.
        mq = 0; mt = 1'b1; mo = 1'b1;
        for (int i = 0; i < 40; i++) begin
            e = 1'($urandom_range(0, 1));
            u = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            en = e; up_down = u; sat = s;
            mt = 1'b0;
            if (e) begin
                if (u) begin
                    if (mq == 15) begin
                        mt = 1'b1; mo = 1'b1;
                        if (!s) mq = 0;
                    end else begin
                        mq = mq + 1;
                    end
                end else begin
                    if (mq == 0) begin
                        mt = 1'b1; mo = 1'b1;
                        if (!s) mq = 15;
                    end else begin
                        mq = mq - 1;
                    end
                end
            end
            step();
            chk($sformatf("rand %0d q", i), q16, mq);
            chk($sformatf("rand %0d tc", i), tc16, mt);
            chk($sformatf("rand %0d ovf", i), ovf16, mo);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
